// File: rtl/updown_counter_pkg.sv
// Shared types and constants for the configurable up/down counter.
package updown_counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } count_mode_e;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/updown_counter_prescaler.sv
// Enable-gated prescaler: emits one tick every PRESCALE enabled cycles.
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic restart_i,
  output logic tick_o
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, restart_i};
      assign tick_o = en_i;
    end else begin : g_div
      localparam int CNT_W = $clog2(PRESCALE);
      localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else if (restart_i) begin
          cnt_q <= '0;
        end else if (en_i) begin
          cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
      end

      assign tick_o = en_i && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/updown_counter.sv
// Parametrised up/down event counter with clear, load, wrap/saturate modes,
// prescaler, terminal-count, wrap pulse and sticky overflow flags.
module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dir_i,
  input  count_mode_e      mode_i,
  input  logic [WIDTH-1:0] max_i,
  input  logic             ovf_clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             wrap_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             step;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en_i),
    .restart_i (clr_i | load_i),
    .tick_o    (step)
  );

  // ovf_clr_i acts on its own; a boundary step on the same edge overrides it.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q & ~ovf_clr_i;

    if (clr_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load_i) begin
      count_d = (load_val_i > max_i) ? max_i : load_val_i;
    end else if (step) begin
      if (dir_i == DIR_UP) begin
        if (count_q < max_i) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          ovf_d = 1'b1;
          if (mode_i == MODE_WRAP) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = max_i;
          end
        end
      end else begin
        if (count_q > max_i) begin
          count_d = max_i;
        end else if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          ovf_d = 1'b1;
          if (mode_i == MODE_WRAP) begin
            count_d = max_i;
            wrap_d  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tc_o    = (dir_i == DIR_DOWN) ? (count_q == '0) : (count_q >= max_i);
  assign count_o = count_q;
  assign wrap_o  = wrap_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter: a PRESCALE=1 and a PRESCALE=3 instance
// share stimulus; expected {count,wrap,ovf,tc} tuples are queued and popped per cycle.
module tb_updown_counter;
  import updown_counter_pkg::*;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] count;
    logic         wrap;
    logic         ovf;
    logic         tc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, clr, load, dir, ovf_clr;
  logic [W-1:0] load_val, max_v;
  count_mode_e  mode;

  logic [W-1:0] count_a, count_b;
  logic         tc_a, wrap_a, ovf_a;
  logic         tc_b, wrap_b, ovf_b;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(W), .PRESCALE(1)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en),
    .clr_i      (clr),
    .load_i     (load),
    .load_val_i (load_val),
    .dir_i      (dir),
    .mode_i     (mode),
    .max_i      (max_v),
    .ovf_clr_i  (ovf_clr),
    .count_o    (count_a),
    .tc_o       (tc_a),
    .wrap_o     (wrap_a),
    .ovf_o      (ovf_a)
  );

  updown_counter #(.WIDTH(W), .PRESCALE(3)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en),
    .clr_i      (clr),
    .load_i     (load),
    .load_val_i (load_val),
    .dir_i      (dir),
    .mode_i     (mode),
    .max_i      (max_v),
    .ovf_clr_i  (ovf_clr),
    .count_o    (count_b),
    .tc_o       (tc_b),
    .wrap_o     (wrap_b),
    .ovf_o      (ovf_b)
  );

  function automatic exp_t mk(input int c, input logic w, input logic o, input logic t);
    exp_t r;
    r.count = W'(c);
    r.wrap  = w;
    r.ovf   = o;
    r.tc    = t;
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
    dir = DIR_UP; mode = MODE_WRAP; max_v = 4'd9; ovf_clr = 1'b0;
    sb.push_back(mk(0, 0, 0, 0));
    cycle();
    cycle();
    e = sb.pop_front();
    n_cmp++;
    if ({count_a, wrap_a, ovf_a, tc_a} !== e) begin
      n_bad++;
      $display("[TB] FAIL reset_hold: got count=%0d wrap=%b ovf=%b tc=%b, want count=%0d wrap=%b ovf=%b tc=%b",
               count_a, wrap_a, ovf_a, tc_a, e.count, e.wrap, e.ovf, e.tc);
    end
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      sb.push_back(mk(i, 0, 0, 0));
      cycle();
      e = sb.pop_front();
      n_cmp++;
      if ({count_a, wrap_a, ovf_a, tc_a} !== e) begin
        n_bad++;
        $display("[TB] FAIL reset_count%0d: got count=%0d wrap=%b ovf=%b tc=%b, want count=%0d wrap=%b ovf=%b tc=%b",
                 i, count_a, wrap_a, ovf_a, tc_a, e.count, e.wrap, e.ovf, e.tc);
      end
    end
    #2 rst = 1'b1;
    sb.push_back(mk(0, 0, 0, 0));
    #1;
    e = sb.pop_front();
    n_cmp++;
    if ({count_a, wrap_a, ovf_a, tc_a} !== e) begin
      n_bad++;
      $display("[TB] FAIL reset_async: got count=%0d wrap=%b ovf=%b tc=%b, want count=%0d wrap=%b ovf=%b tc=%b",
               count_a, wrap_a, ovf_a, tc_a, e.count, e.wrap, e.ovf, e.tc);
    end
    #1 rst = 1'b0;
    sb.push_back(mk(1, 0, 0, 0));
    cycle();
    e = sb.pop_front();
    n_cmp++;
    if ({count_a, wrap_a, ovf_a, tc_a} !== e) begin
      n_bad++;
      $display("[TB] FAIL reset_resume: got count=%0d wrap=%b ovf=%b tc=%b, want count=%0d wrap=%b ovf=%b tc=%b",
               count_a, wrap_a, ovf_a, tc_a, e.count, e.wrap, e.ovf, e.tc);
    end
    en = 1'b0;
  endtask

  task automatic test_wrap_up();
    clr = 1'b1;
    sb.push_back(mk(0, 0, 0, 0));
    cycle();
    clr = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if ({count_a, wrap_a, ovf_a, tc_a} !== e) begin
      n_bad++;
      $display("[TB] FAIL wrap_clr: got count=%0d wrap=%b ovf=%b tc=%b, want count=%0d wrap=%b ovf=%b tc=%b",
               count_a, wrap_a, ovf_a, tc_a, e.count, e.wrap, e.ovf, e.tc);
    end
    for (int i = 1; i <= 12; i++) begin
      en = (i <= 10);
      if (i < 10)       sb.push_back(mk(i, 0, 0, i == 9));
      else if (i == 10) sb.push_back(mk(0, 1, 1, 0));
      else              sb.push_back(mk(0, 0, 1, 0));
      cycle();
      e = sb.pop_front();
      n_cmp++;
      if ({count_a, wrap_a, ovf_a, tc_a} !== e) begin
        n_bad++;
        $display("[TB] FAIL wrap_step%0d: got count=%0d wrap=%b ovf=%b tc=%b, want count=%0d wrap=%b ovf=%b tc=%b",
                 i, count_a, wrap_a, ovf_a, tc_a, e.count, e.wrap, e.ovf, e.tc);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_sat_down();
    mode = MODE_SAT;
    dir  = DIR_DOWN;
    ovf_clr = 1'b1;
    sb.push_back(mk(0, 0, 0, 1));
    cycle();
    ovf_clr  = 1'b0;
    load     = 1'b1;
    load_val = 4'd3;
    sb.push_back(mk(3, 0, 0, 0));
    cycle();
    load = 1'b0;
    en   = 1'b1;
    sb.push_back(mk(2, 0, 0, 0));
    sb.push_back(mk(1, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 1));
    sb.push_back(mk(0, 0, 1, 1));
    sb.push_back(mk(0, 0, 1, 1));
    for (int i = 0; i < 7; i++) begin
      // The first two queued entries belong to edges that already happened.
      if (i >= 2) cycle();
      e = sb.pop_front();
      n_cmp++;
      if (i == 0) begin
        // ovf_clr edge result was overwritten by the load edge; check the load result instead.
        e = sb.pop_front();
        i++;
      end
      if ({count_a, wrap_a, ovf_a, tc_a} !== e) begin
        n_bad++;
        $display("[TB] FAIL sat_down%0d: got count=%0d wrap=%b ovf=%b tc=%b, want count=%0d wrap=%b ovf=%b tc=%b",
                 i, count_a, wrap_a, ovf_a, tc_a, e.count, e.wrap, e.ovf, e.tc);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_priority_clamp();
    mode = MODE_WRAP;
    dir  = DIR_UP;
    clr = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b1;
    sb.push_back(mk(0, 0, 0, 0));
    cycle();
    e = sb.pop_front();
    n_cmp++;
    if ({count_a, wrap_a, ovf_a, tc_a} !== e) begin
      n_bad++;
      $display("[TB] FAIL prio_clr: got count=%0d wrap=%b ovf=%b tc=%b, want count=%0d wrap=%b ovf=%b tc=%b",
               count_a, wrap_a, ovf_a, tc_a, e.count, e.wrap, e.ovf, e.tc);
    end
    clr = 1'b0; load_val = 4'd12; en = 1'b0;
    sb.push_back(mk(9, 0, 0, 1));
    cycle();
    e = sb.pop_front();
    n_cmp++;
    if ({count_a, wrap_a, ovf_a, tc_a} !== e) begin
      n_bad++;
      $display("[TB] FAIL load_clamp: got count=%0d wrap=%b ovf=%b tc=%b, want count=%0d wrap=%b ovf=%b tc=%b",
               count_a, wrap_a, ovf_a, tc_a, e.count, e.wrap, e.ovf, e.tc);
    end
    load = 1'b0; max_v = 4'd4; en = 1'b1;
    sb.push_back(mk(0, 1, 1, 0));
    cycle();
    en = 1'b0;
    sb.push_back(mk(0, 0, 1, 0));
    for (int i = 0; i < 2; i++) begin
      if (i == 1) cycle();
      e = sb.pop_front();
      n_cmp++;
      if ({count_a, wrap_a, ovf_a, tc_a} !== e) begin
        n_bad++;
        $display("[TB] FAIL max_lowered%0d: got count=%0d wrap=%b ovf=%b tc=%b, want count=%0d wrap=%b ovf=%b tc=%b",
                 i, count_a, wrap_a, ovf_a, tc_a, e.count, e.wrap, e.ovf, e.tc);
      end
    end
  endtask

  task automatic test_ovf_clear();
    dir = DIR_DOWN; en = 1'b1; ovf_clr = 1'b1;
    sb.push_back(mk(4, 1, 1, 0));
    cycle();
    e = sb.pop_front();
    n_cmp++;
    if ({count_a, wrap_a, ovf_a, tc_a} !== e) begin
      n_bad++;
      $display("[TB] FAIL ovf_set_wins: got count=%0d wrap=%b ovf=%b tc=%b, want count=%0d wrap=%b ovf=%b tc=%b",
               count_a, wrap_a, ovf_a, tc_a, e.count, e.wrap, e.ovf, e.tc);
    end
    en = 1'b0;
    sb.push_back(mk(4, 0, 0, 0));
    cycle();
    ovf_clr = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if ({count_a, wrap_a, ovf_a, tc_a} !== e) begin
      n_bad++;
      $display("[TB] FAIL ovf_clear: got count=%0d wrap=%b ovf=%b tc=%b, want count=%0d wrap=%b ovf=%b tc=%b",
               count_a, wrap_a, ovf_a, tc_a, e.count, e.wrap, e.ovf, e.tc);
    end
  endtask

  task automatic test_prescale();
    int en_cycles;
    dir = DIR_UP; mode = MODE_WRAP; max_v = 4'd15;
    clr = 1'b1; en = 1'b0;
    sb.push_back(mk(0, 0, 0, 0));
    cycle();
    clr = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if ({count_b, wrap_b, ovf_b, tc_b} !== e) begin
      n_bad++;
      $display("[TB] FAIL ps_clr: got count=%0d wrap=%b ovf=%b tc=%b, want count=%0d wrap=%b ovf=%b tc=%b",
               count_b, wrap_b, ovf_b, tc_b, e.count, e.wrap, e.ovf, e.tc);
    end
    en_cycles = 0;
    for (int i = 0; i < 17; i++) begin
      en = (i < 9) || (i >= 14);
      if (en) en_cycles++;
      sb.push_back(mk(en_cycles / 3, 0, 0, 0));
      cycle();
      e = sb.pop_front();
      n_cmp++;
      if ({count_b, wrap_b, ovf_b, tc_b} !== e) begin
        n_bad++;
        $display("[TB] FAIL ps_cycle%0d: got count=%0d wrap=%b ovf=%b tc=%b, want count=%0d wrap=%b ovf=%b tc=%b",
                 i, count_b, wrap_b, ovf_b, tc_b, e.count, e.wrap, e.ovf, e.tc);
      end
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_priority_clamp();
    test_ovf_clear();
    test_prescale();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
Name: updown_counter

Overview:
Parametrised successor to the team's free-running 2-bit counter. The width, modulo limit and direction are all configurable.
- Adds an enable, a synchronous clear, a parallel load, wrap/saturate modes, a clock prescaler and status flags.
- Used as the general-purpose event/timebase counter throughout the design.
- Single clock domain.

Parameters:
WIDTH, 8, count register width in bits (>=1)
PRESCALE, 1, number of enabled cycles per count step (>=1; 1 = step every enabled cycle)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
en_i  input  1  count enable; gates both prescaler and counter
clr_i  input  1  synchronous clear
load_i  input  1  synchronous parallel load
load_val_i  input  WIDTH  value loaded when load_i=1
dir_i  input  1  1 = count up, 0 = count down
mode_i  input  1  0 = wrap, 1 = saturate (enum from package)
max_i  input  WIDTH  inclusive upper limit of count range
ovf_clr_i  input  1  clears sticky overflow flag
count_o  output  WIDTH  current count (registered)
tc_o  output  1  terminal count: next step hits a boundary (combinational)
wrap_o  output  1  one-cycle pulse after a wrap occurred (registered)
ovf_o  output  1  sticky boundary-event flag (registered)

Behaviour:
- Reset behaviour: rst=1 forces count_o=0, wrap_o=0, ovf_o=0 and prescaler=0 immediately, without waiting for clk. State holds while rst=1.
- Prescaler:
  - Counts 0..PRESCALE-1, advancing only when en_i=1.
  - tick=1 when prescaler==PRESCALE-1 and en_i=1; the prescaler then returns to 0.
  - clr_i or load_i resets the prescaler to 0.
- step = en_i & tick. When PRESCALE=1, step = en_i.
- Priority per edge: clr_i > load_i > step > hold.
- clr_i: count_o<=0 and ovf_o<=0. wrap_o<=0.
- load_i: count_o<=min(load_val_i, max_i). Flags are unchanged except that wrap_o<=0.
- Up step:
  - If count_o<max_i: count+1.
  - Else (boundary, including count_o>max_i after max_i is lowered): wrap mode gives count<=0 and wrap_o<=1; sat mode gives count<=max_i. Both modes set ovf_o<=1.
- Down step:
  - If count_o>max_i: count<=max_i (clamp, not a boundary).
  - Else if count_o>0: count-1.
  - Else (count 0 = boundary): wrap mode gives count<=max_i and wrap_o<=1; sat mode holds 0. Both modes set ovf_o<=1.
- Latency: the new count is visible one cycle after the step edge. wrap_o is high for exactly the one cycle after the wrapping edge, otherwise 0.
- tc_o = dir_i ? (count_o>=max_i) : (count_o==0). It is purely combinational and independent of en_i.
- ovf_o:
  - Sticky. Cleared by ovf_clr_i or clr_i.
  - If a boundary step and ovf_clr_i occur on the same edge, set wins (ovf_o=1).
- Arithmetic: unsigned, WIDTH bits. Internal increment/decrement never overflows because boundaries are checked first.
- max_i=0: count stays 0. Every step is a boundary, so in wrap mode wrap_o pulses after each step.
- Changing dir_i or mode_i mid-count is legal and takes effect on the next step.
- No X-propagation: all outputs are defined from reset onward.

Decomposition:
- Package updown_counter_pkg:
  - Enum count_mode_e {MODE_WRAP=1'b0, MODE_SAT=1'b1}.
  - Constants DIR_DOWN=1'b0 and DIR_UP=1'b1.
- Sub-module counter_prescaler:
  - Parameter PRESCALE.
  - Ports clk, rst, en_i, restart_i, tick_o.
  - Width $clog2(PRESCALE) with a minimum of 1. Ties tick_o=en_i when PRESCALE=1.
- Top: next-state logic, flag registers and tc_o.

Test Plan:
1. WIDTH=4, PRESCALE=1. Count to 5, then pulse rst between clock edges -> count_o=0, wrap_o=0, ovf_o=0 before the next edge; counting resumes from 0 after release.
2. Wrap up: max_i=9, mode wrap, dir up, en_i high 10 cycles from 0 -> count 1..9 then 0. tc_o=1 while count=9. wrap_o high exactly one cycle after the 9->0 edge. ovf_o=1 and stays 1.
3. Saturate down: load 3, dir down, mode sat, 5 steps -> counts 2,1,0,0,0. ovf_o rises after the 4th step. wrap_o never asserts.
4. Priority/clamp: clr_i, load_i and en_i together -> count 0. Then load_val_i=12 with max_i=9 -> count 9. Then lower max_i to 4 and step up -> count 0 with wrap_o pulse (wrap mode).
5. PRESCALE=3: en_i high 9 cycles -> count 3. en_i low 5 cycles -> count and prescaler frozen. en_i high 3 more cycles -> count 4.
6. Overflow clear: ovf_clr_i on the same edge as a boundary step -> ovf_o stays 1. ovf_clr_i alone on the next edge -> ovf_o=0.
